// File: rtl/l2_bus_pkg.sv
// ---------------------------------------------------------------------------
// l2_bus_pkg
// Shared definitions for the L2 trace-bench shared bus:
//   snoop_t        - snoop result encoding (HIT/HITM/NOHIT; 2'b11 unused)
//   OP_*           - ASCII bus-op codes carried on the snoop request
//   combine_snoop  - merges two snoop results, HITM > HIT > NOHIT
// ---------------------------------------------------------------------------
package l2_bus_pkg;

    typedef enum logic [1:0] {
        HIT   = 2'b00,
        HITM  = 2'b01,
        NOHIT = 2'b10
    } snoop_t;

    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] OP_RWIM  = 8'h4D;  // 'M'
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_INVAL = 8'h49;  // 'I'

    function automatic snoop_t combine_snoop(input snoop_t a, input snoop_t b);
        if (a == HITM || b == HITM) return HITM;
        if (a == HIT || b == HIT) return HIT;
        return NOHIT;
    endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// ---------------------------------------------------------------------------
// snoop_responder_if
// Request/response handshake bundle between the shared bus and the snoop
// responder.
//   req_*      : snoop request (valid/ready, address, ASCII op, force override)
//   rsp_*      : in-order snoop response (valid/ready, combined result,
//                per-agent vector, unknown-op flag)
// Modports: master = bus/trace side, slave = responder.
// ---------------------------------------------------------------------------
interface snoop_responder_if #(
    parameter int ADDR_W   = 32,
    parameter int N_AGENTS = 2
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_W-1:0]       req_addr;
    logic [7:0]              req_op;
    logic                    force_en;
    logic [1:0]              force_rsp;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_result;
    logic [2*N_AGENTS-1:0]   rsp_vec;
    logic                    rsp_err;

    modport master (
        output req_valid, req_addr, req_op, force_en, force_rsp, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_vec, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_op, force_en, force_rsp, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_vec, rsp_err
    );
endinterface

// File: rtl/snoop_fifo.sv
// ---------------------------------------------------------------------------
// snoop_fifo
// In-order pending-result queue with a per-entry maturity countdown.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write push_data (caller guarantees !full)
//   pop         : retire head (caller guarantees head_ready)
//   head_data   : payload of the oldest entry
//   head_ready  : queue non-empty and head countdown expired
//   full        : count == DEPTH (no same-cycle pop bypass)
// ---------------------------------------------------------------------------
module snoop_fifo #(
    parameter int WIDTH   = 7,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_ready,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [3:0]       cd_q  [DEPTH];
    logic [3:0]       cd_d  [DEPTH];
    logic [DEPTH-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_data  = mem_q[rd_ptr_q];
    // Entries are filled in order, so the head slot is occupied iff non-empty.
    assign head_ready = occ_q[rd_ptr_q] && (cd_q[rd_ptr_q] == 4'd0);

    always_comb begin
        mem_d    = mem_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Every occupied entry ages, including ones stuck behind a held head.
        for (int i = 0; i < DEPTH; i++) begin
            cd_d[i] = (occ_q[i] && cd_q[i] != 4'd0) ? cd_q[i] - 4'd1 : cd_q[i];
        end
        if (pop) begin
            occ_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        // A push never targets the head slot being popped: that needs full.
        if (push) begin
            occ_d[wr_ptr_q] = 1'b1;
            cd_d[wr_ptr_q]  = 4'(LATENCY - 1);
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) cd_q[i] <= 4'd0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cd_q     <= cd_d;
        end
    end

    // Payload needs no reset: it is only observed through occupied slots.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/snoop_responder.sv
// ---------------------------------------------------------------------------
// snoop_responder
// Decodes shared-bus snoop requests into per-agent snoop results, queues them
// and returns them in order after LATENCY cycles; keeps saturating per-result
// response statistics.
//   clk, reset              : clock, asynchronous active-high reset
//   bus (slave)             : request/response handshake, see snoop_responder_if
//   hit_cnt/hitm_cnt/
//   nohit_cnt               : combined-result counts of transferred responses
// ---------------------------------------------------------------------------
module snoop_responder
    import l2_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int N_AGENTS = 2,
    parameter int DEPTH    = 4,
    parameter int LATENCY  = 2
) (
    input  logic               clk,
    input  logic               reset,
    snoop_responder_if.slave   bus,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        hitm_cnt,
    output logic [15:0]        nohit_cnt
);
    localparam int VEC_W   = 2 * N_AGENTS;
    localparam int ENTRY_W = VEC_W + 3;   // {err, result, vec}

    logic               op_rm, op_wi;
    logic [VEC_W-1:0]   req_vec;
    snoop_t             req_result;
    logic               req_err;
    logic               push, pop, full, head_ready;
    logic [ENTRY_W-1:0] head_data;
    logic [1:0]         head_result;
    logic [15:0]        hit_cnt_q, hit_cnt_d;
    logic [15:0]        hitm_cnt_q, hitm_cnt_d;
    logic [15:0]        nohit_cnt_q, nohit_cnt_d;

    function automatic snoop_t decode_agent(input logic [1:0] a);
        case (a)
            2'b00:   return HIT;
            2'b01:   return HITM;
            default: return NOHIT;
        endcase
    endfunction

    // 2'b11 is not a legal result code, so a forced 11 degrades to NOHIT.
    function automatic snoop_t force_value(input logic [1:0] f);
        return (f == 2'b11) ? NOHIT : snoop_t'(f);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        op_rm      = (bus.req_op == OP_READ) || (bus.req_op == OP_WRITE ? 1'b0 : bus.req_op == OP_RWIM);
        op_wi      = (bus.req_op == OP_WRITE) || (bus.req_op == OP_INVAL);
        req_result = NOHIT;
        req_vec    = '0;
        for (int i = 0; i < N_AGENTS; i++) begin
            snoop_t agent;
            agent = NOHIT;
            if (op_rm) begin
                agent = bus.force_en ? force_value(bus.force_rsp)
                                     : decode_agent(bus.req_addr[2*i +: 2]);
            end
            req_vec[2*i +: 2] = agent;
            req_result        = combine_snoop(req_result, agent);
        end
        // Unknown ops still occupy a slot and are counted as NOHIT.
        req_err = !(op_rm || op_wi);
    end

    assign push = bus.req_valid && bus.req_ready;
    assign pop  = bus.rsp_valid && bus.rsp_ready;

    snoop_fifo #(
        .WIDTH   (ENTRY_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  ({req_err, req_result, req_vec}),
        .pop        (pop),
        .head_data  (head_data),
        .head_ready (head_ready),
        .full       (full)
    );

    assign head_result    = head_data[VEC_W +: 2];
    assign bus.req_ready  = !full;
    assign bus.rsp_valid  = head_ready;
    assign bus.rsp_result = head_ready ? head_result : 2'b00;
    assign bus.rsp_vec    = head_ready ? head_data[VEC_W-1:0] : '0;
    assign bus.rsp_err    = head_ready ? head_data[ENTRY_W-1] : 1'b0;

    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        hitm_cnt_d  = hitm_cnt_q;
        nohit_cnt_d = nohit_cnt_q;
        if (pop) begin
            case (head_result)
                HIT:     hit_cnt_d   = sat_inc(hit_cnt_q);
                HITM:    hitm_cnt_d  = sat_inc(hitm_cnt_q);
                default: nohit_cnt_d = sat_inc(nohit_cnt_q);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q   <= 16'd0;
            hitm_cnt_q  <= 16'd0;
            nohit_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            hitm_cnt_q  <= hitm_cnt_d;
            nohit_cnt_q <= nohit_cnt_d;
        end
    end

    assign hit_cnt   = hit_cnt_q;
    assign hitm_cnt  = hitm_cnt_q;
    assign nohit_cnt = nohit_cnt_q;
endmodule

// File: tb/tb_snoop_responder.sv
// ---------------------------------------------------------------------------
// tb_snoop_responder
// Directed-vector bench for snoop_responder (ADDR_W=32, N_AGENTS=2, DEPTH=4,
// LATENCY=2). Inputs change and outputs are sampled on the falling clock edge.
// Response words are packed as {rsp_err, rsp_result, rsp_vec}.
// ---------------------------------------------------------------------------
module tb_snoop_responder;
    import l2_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hit_cnt, hitm_cnt, nohit_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    snoop_responder_if #(.ADDR_W(32), .N_AGENTS(2)) bus ();

    snoop_responder #(
        .ADDR_W   (32),
        .N_AGENTS (2),
        .DEPTH    (4),
        .LATENCY  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .hit_cnt   (hit_cnt),
        .hitm_cnt  (hitm_cnt),
        .nohit_cnt (nohit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] rsp_word();
        return {bus.rsp_err, bus.rsp_result, bus.rsp_vec};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Enters and leaves on a falling edge; returns one edge after acceptance.
    task automatic send(input logic [31:0] addr, input logic [7:0] op,
                        input logic fen, input logic [1:0] frsp);
        int n;
        n = 0;
        bus.req_addr  = addr;
        bus.req_op    = op;
        bus.force_en  = fen;
        bus.force_rsp = frsp;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_vec("send_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        bus.force_en  = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [6:0] exp);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check_vec({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check_vec(tag, {25'd0, rsp_word()}, {25'd0, exp});
        tick();
    endtask

    task automatic txn(input string tag, input logic [31:0] addr, input logic [7:0] op,
                       input logic fen, input logic [1:0] frsp, input logic [6:0] exp);
        bus.rsp_ready = 1'b1;
        send(addr, op, fen, frsp);
        wait_rsp(tag, exp);
    endtask

    // Exact-latency check for LATENCY=2 from an empty queue.
    task automatic lat_check(input string tag, input logic [31:0] addr,
                             input logic [7:0] op, input logic [6:0] exp);
        bus.rsp_ready = 1'b1;
        send(addr, op, 1'b0, 2'b00);
        check_vec({tag, "_early"}, {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check_vec({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check_vec({tag, "_data"}, {25'd0, rsp_word()}, {25'd0, exp});
        tick();
        check_vec({tag, "_popped"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic check_counts(input string tag, input logic [15:0] h,
                                input logic [15:0] hm, input logic [15:0] nh);
        check_vec({tag, "_hit"},   {16'd0, hit_cnt},   {16'd0, h});
        check_vec({tag, "_hitm"},  {16'd0, hitm_cnt},  {16'd0, hm});
        check_vec({tag, "_nohit"}, {16'd0, nohit_cnt}, {16'd0, nh});
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check_vec({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check_vec({tag, "_rsp_word"},  {25'd0, rsp_word()}, 32'd0);
        check_counts(tag, 16'd0, 16'd0, 16'd0);
    endtask

    // Back-to-back run: addr = index, op 'R'; {result, vec} per index.
    logic [5:0] b2b_exp [12] = '{
        6'b00_0000, 6'b01_0001, 6'b00_0010, 6'b00_0010,
        6'b01_0100, 6'b01_0101, 6'b01_0110, 6'b01_0110,
        6'b00_1000, 6'b01_1001, 6'b10_1010, 6'b10_1010
    };
    // Backpressure run: addr 0, 1, 2, 5, A, op 'R'.
    logic [31:0] bp_addr [5] = '{32'h0, 32'h1, 32'h2, 32'h5, 32'hA};
    logic [6:0]  bp_exp  [5] = '{7'b0_00_0000, 7'b0_01_0001, 7'b0_00_0010,
                                 7'b0_01_0101, 7'b0_10_1010};

    initial begin
        int  sent, got, n, extra, stalls;
        logic acc;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_op    = OP_READ;
        bus.force_en  = 1'b0;
        bus.force_rsp = 2'b00;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        // Single read request: agent0 HITM, agent1 HIT.
        lat_check("single", 32'h0000_0001, OP_READ, 7'b0_01_0001);
        check_counts("single", 16'd0, 16'd1, 16'd0);

        // Decode, priority, force and op handling.
        txn("rwim_hit",    32'h0, OP_RWIM,  1'b0, 2'b00, 7'b0_00_0000);
        txn("force_11",    32'h0, OP_READ,  1'b1, 2'b11, 7'b0_10_1010);
        txn("force_hitm",  32'hA, OP_RWIM,  1'b1, 2'b01, 7'b0_01_0101);
        txn("write",       32'h1, OP_WRITE, 1'b0, 2'b00, 7'b0_10_1010);
        txn("unknown_op",  32'h1, 8'h58,    1'b0, 2'b00, 7'b1_10_1010);
        txn("prio_hitm",   32'h6, OP_READ,  1'b0, 2'b00, 7'b0_01_0110);
        txn("prio_hit",    32'h8, OP_READ,  1'b0, 2'b00, 7'b0_00_1000);
        txn("inval_force", 32'h0, OP_INVAL, 1'b1, 2'b00, 7'b0_10_1010);
        check_counts("decode", 16'd2, 16'd3, 16'd4);

        // Backpressure: fill DEPTH=4, 5th waits for space.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(bp_addr[i], OP_READ, 1'b0, 2'b00);
        check_vec("bp_full", {31'd0, bus.req_ready}, 32'd0);
        bus.req_addr  = bp_addr[4];
        bus.req_op    = OP_READ;
        bus.req_valid = 1'b1;
        repeat (3) tick();
        check_vec("bp_still_full", {31'd0, bus.req_ready}, 32'd0);
        check_vec("bp_head_hold", {25'd0, rsp_word()}, {25'd0, bp_exp[0]});
        bus.rsp_ready = 1'b1;
        got = 0;
        n   = 0;
        while (got < 5 && n < 40) begin
            if (bus.rsp_valid) begin
                check_vec($sformatf("bp_rsp%0d", got), {25'd0, rsp_word()}, {25'd0, bp_exp[got]});
                got++;
            end
            acc = bus.req_valid && bus.req_ready;
            tick();
            n++;
            if (acc) begin
                bus.req_valid = 1'b0;
                check_vec("bp_5th_after_pop", {31'd0, got >= 1}, 32'd1);
            end
        end
        check_vec("bp_count", got, 32'd5);
        check_counts("bp", 16'd4, 16'd5, 16'd5);

        // Back-to-back stream: pointers wrap several times.
        sent = 0; got = 0; n = 0; extra = 0; stalls = 0;
        bus.rsp_ready = 1'b1;
        while ((sent < 12 || got < 12) && n < 100) begin
            bus.req_valid = (sent < 12);
            bus.req_addr  = sent;
            bus.req_op    = OP_READ;
            acc = bus.req_valid && bus.req_ready;
            if (bus.req_valid && !bus.req_ready) stalls++;
            if (bus.rsp_valid) begin
                if (got < 12)
                    check_vec($sformatf("b2b_rsp%0d", got), {25'd0, rsp_word()}, {25'd0, 1'b0, b2b_exp[got]});
                else
                    extra++;
                got++;
            end
            tick();
            n++;
            if (acc) sent++;
        end
        bus.req_valid = 1'b0;
        repeat (3) begin
            if (bus.rsp_valid) extra++;
            tick();
        end
        check_vec("b2b_got", got, 32'd12);
        check_vec("b2b_extra", extra, 32'd0);
        check_vec("b2b_stalls", stalls, 32'd0);
        check_counts("b2b", 16'd8, 16'd11, 16'd7);

        // Asynchronous reset with three pending entries.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h1, OP_READ, 1'b0, 2'b00);
        check_vec("rst_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2 reset = 1'b1;
        #1 check_idle("async_rst");
        tick();
        check_idle("rst_held");
        reset = 1'b0;
        tick();
        lat_check("post_rst", 32'h0, OP_RWIM, 7'b0_00_0000);
        check_counts("post_rst", 16'd1, 16'd0, 16'd0);

        // Saturation: stream 65534 HITs, then two more.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        sent = 0; got = 0; n = 0;
        bus.rsp_ready = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_op    = OP_RWIM;
        while ((sent < 65534 || got < 65534) && n < 70000) begin
            bus.req_valid = (sent < 65534);
            acc = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) got++;
            tick();
            n++;
            if (acc) sent++;
        end
        bus.req_valid = 1'b0;
        check_vec("sat_drain", got, 32'd65534);
        check_vec("sat_fffe", {16'd0, hit_cnt}, 32'h0000_FFFE);
        txn("sat_a", 32'h0, OP_RWIM, 1'b0, 2'b00, 7'b0_00_0000);
        check_vec("sat_ffff", {16'd0, hit_cnt}, 32'h0000_FFFF);
        txn("sat_b", 32'h0, OP_RWIM, 1'b0, 2'b00, 7'b0_00_0000);
        check_counts("sat_hold", 16'hFFFF, 16'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
